maze_memory: RTL and testbench



---
 rtl/maze_pkg.sv | 16 +
 rtl/maze_cell_ram.sv | 53 +++++
 rtl/maze_memory.sv | 171 +++++++++++++++++
 tb/tb_maze_memory.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze grid store: cell codes, default grid width, FSM states.
package maze_pkg;

    localparam int unsigned MAZE_WIDTH = 6;

    localparam logic [1:0] CELL_FREE    = 2'd0;
    localparam logic [1:0] CELL_WALL    = 2'd1;
    localparam logic [1:0] CELL_VISITED = 2'd2;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SERVE  = 2'd1,
        FROZEN = 2'd2
    } state_t;

endpackage

// File: rtl/maze_cell_ram.sv
// 2-bit cell array: one write port with a same-address peek, one registered read port
// (a second registered read port when MAZE_MEM_DUMP_EN is defined).
module maze_cell_ram
    import maze_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    output logic [1:0]    wold,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
`ifdef MAZE_MEM_DUMP_EN
    ,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [1:0]    rdata2
`endif
);

    logic [1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Current contents at the write address, so the owner can decide how to update the cell.
    assign wold = mem[waddr];

    // Reset to WALL so the solver-facing read bit comes out of reset as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= CELL_WALL;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef MAZE_MEM_DUMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata2 <= CELL_FREE;
        end else if (re2) begin
            rdata2 <= mem[raddr2];
        end
    end
`endif

endmodule

// File: rtl/maze_memory.sv
// Maze grid store on the solver bus: serial load, read/visit service, freeze on done.
// Optional cell dump stream in the frozen state when MAZE_MEM_DUMP_EN is defined.
module maze_memory
    import maze_pkg::*;
#(
    parameter int unsigned maze_width = MAZE_WIDTH,
    parameter int unsigned CNT_W      = 2 * maze_width + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic                  load_wall,
    output logic                  load_ready,
    output logic                  maze_ready,
    input  logic [maze_width-1:0] row,
    input  logic [maze_width-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    input  logic                  done,
    output logic                  maze_in,
    output logic [CNT_W-1:0]      visited_count,
    output logic                  wall_write_err,
    output logic                  frozen
`ifdef MAZE_MEM_DUMP_EN
    ,
    output logic                  dump_valid,
    output logic [1:0]            dump_data,
    output logic                  dump_last,
    input  logic                  dump_ready
`endif
);

    localparam int unsigned AW = 2 * maze_width;
    localparam logic [AW-1:0] LAST_IDX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1 << AW);

    state_t          state_q;
    logic [AW-1:0]   load_idx_q;
    logic            load_ready_q;
    logic            maze_ready_q;
    logic [CNT_W-1:0] count_q;
    logic            err_q;
    logic            frozen_q;

    logic            load_fire;
    logic            serve_we;
    logic [AW-1:0]   cell_addr;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [1:0]      ram_wdata;
    logic [1:0]      ram_wold;
    logic            ram_re;
    logic [1:0]      ram_rdata;

    assign cell_addr = {row, col};
    assign load_fire = load_valid & load_ready_q;
    assign serve_we  = (state_q == SERVE) & maze_we;
    assign ram_re    = maze_oe & (state_q != LOAD);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cell_addr;
        ram_wdata = CELL_VISITED;
        if (state_q == LOAD) begin
            ram_we    = load_fire;
            ram_waddr = load_idx_q;
            ram_wdata = load_wall ? CELL_WALL : CELL_FREE;
        end else begin
            // Only FREE cells change on a visit; walls and visited cells are left alone.
            ram_we = serve_we & (ram_wold == CELL_FREE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            load_idx_q   <= '0;
            load_ready_q <= 1'b0;
            maze_ready_q <= 1'b0;
            count_q      <= '0;
            err_q        <= 1'b0;
            frozen_q     <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    load_ready_q <= 1'b1;
                    if (load_fire) begin
                        load_idx_q <= load_idx_q + 1'b1;
                        if (load_idx_q == LAST_IDX) begin
                            state_q      <= SERVE;
                            load_ready_q <= 1'b0;
                            maze_ready_q <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (serve_we) begin
                        if (ram_wold == CELL_FREE && count_q != CNT_MAX) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (ram_wold == CELL_WALL) err_q <= 1'b1;
                    end
                    if (done) begin
                        state_q  <= FROZEN;
                        frozen_q <= 1'b1;
                    end
                end
                FROZEN: begin
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign load_ready     = load_ready_q;
    assign maze_ready     = maze_ready_q;
    assign maze_in        = (ram_rdata == CELL_WALL);
    assign visited_count  = count_q;
    assign wall_write_err = err_q;
    assign frozen         = frozen_q;

`ifdef MAZE_MEM_DUMP_EN
    logic [AW:0]   dump_idx_q;
    logic          dump_valid_q;
    logic          dump_last_q;
    logic          dump_fetch;
    logic [1:0]    dump_rdata;

    // Fetch the next cell whenever the output slot is empty or being drained this cycle.
    assign dump_fetch = (state_q == FROZEN) & ~dump_idx_q[AW] & (~dump_valid_q | dump_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
        end else if (dump_fetch) begin
            dump_idx_q   <= dump_idx_q + 1'b1;
            dump_valid_q <= 1'b1;
            dump_last_q  <= (dump_idx_q[AW-1:0] == LAST_IDX);
        end else if (dump_ready) begin
            dump_valid_q <= 1'b0;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_rdata;
    assign dump_last  = dump_last_q;
`endif

    maze_cell_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wold  (ram_wold),
        .re    (ram_re),
        .raddr (cell_addr),
        .rdata (ram_rdata)
`ifdef MAZE_MEM_DUMP_EN
        ,
        .re2   (dump_fetch),
        .raddr2(dump_idx_q[AW-1:0]),
        .rdata2(dump_rdata)
`endif
    );

endmodule

// File: tb/tb_maze_memory.sv
// Randomized bench for maze_memory against a cell-array reference model, plus literal checks.
module tb_maze_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid = 1'b0;
    logic        load_wall = 1'b0;
    logic        load_ready;
    logic        maze_ready;
    logic [5:0]  row = '0;
    logic [5:0]  col = '0;
    logic        maze_oe = 1'b0;
    logic        maze_we = 1'b0;
    logic        done = 1'b0;
    logic        maze_in;
    logic [12:0] visited_count;
    logic        wall_write_err;
    logic        frozen;
`ifdef MAZE_MEM_DUMP_EN
    logic        dump_valid;
    logic [1:0]  dump_data;
    logic        dump_last;
    logic        dump_ready = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    maze_memory u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_wall     (load_wall),
        .load_ready    (load_ready),
        .maze_ready    (maze_ready),
        .row           (row),
        .col           (col),
        .maze_oe       (maze_oe),
        .maze_we       (maze_we),
        .done          (done),
        .maze_in       (maze_in),
        .visited_count (visited_count),
        .wall_write_err(wall_write_err),
        .frozen        (frozen)
`ifdef MAZE_MEM_DUMP_EN
        ,
        .dump_valid    (dump_valid),
        .dump_data     (dump_data),
        .dump_last     (dump_last),
        .dump_ready    (dump_ready)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 25) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: phase 0 = loading, 1 = serving, 2 = frozen; cells 0 free, 1 wall, 2 visited.
    int m_cells [4096];
    int m_phase = 0;
    int m_idx = 0;
    bit m_load_ready = 0, m_maze_ready = 0, m_maze_in = 1, m_err = 0, m_frozen = 0;
    int m_count = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_idx = 0; m_load_ready = 0; m_maze_ready = 0;
                m_maze_in = 1; m_count = 0; m_err = 0; m_frozen = 0;
            end else if (m_phase == 0) begin
                if (load_valid && m_load_ready) begin
                    m_cells[m_idx] = load_wall ? 1 : 0;
                    m_idx++;
                    if (m_idx == 4096) begin
                        m_phase = 1;
                        m_maze_ready = 1;
                    end
                end
                m_load_ready = (m_phase == 0);
            end else begin
                int a;
                a = int'(row) * 64 + int'(col);
                if (maze_oe) m_maze_in = (m_cells[a] == 1);
                if (m_phase == 1) begin
                    if (maze_we) begin
                        if (m_cells[a] == 0) begin
                            m_cells[a] = 2;
                            if (m_count < 4096) m_count++;
                        end else if (m_cells[a] == 1) begin
                            m_err = 1;
                        end
                    end
                    if (done) begin
                        m_phase = 2;
                        m_frozen = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("load_ready", load_ready, m_load_ready);
        chk("maze_ready", maze_ready, m_maze_ready);
        chk("maze_in", maze_in, m_maze_in);
        chk("visited_count", visited_count, m_count);
        chk("wall_write_err", wall_write_err, m_err);
        chk("frozen", frozen, m_frozen);
    end

    function automatic bit border_wall(input int idx);
        int r, c;
        r = idx / 64;
        c = idx % 64;
        return (r == 0 || r == 63 || c == 0 || c == 63) && !(r == 0 && c == 5);
    endfunction

    task automatic cyc(input bit oe, input bit we, input bit dn, input int r, input int c);
        @(negedge clk);
        maze_oe = oe;
        maze_we = we;
        done    = dn;
        row     = 6'(r);
        col     = 6'(c);
    endtask

    task automatic read_cell(input int r, input int c, input bit exp, input string nm);
        cyc(1, 0, 0, r, c);
        cyc(0, 0, 0, 0, 0);
        chk(nm, maze_in, exp);
    endtask

    // Feed n cells with random valid gaps while junk toggles the solver bus.
    task automatic load_cells(input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 30000) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 3) != 0);
            load_wall  = border_wall(idx);
            maze_oe    = $urandom_range(0, 1);
            maze_we    = $urandom_range(0, 1);
            row        = 6'($urandom);
            col        = 6'($urandom);
            if (load_valid && load_ready) idx++;
            guard++;
        end
        if (idx < n) chk("load_timeout", 32'(idx), 32'(n));
    endtask

    initial begin
        int cnt_before;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_maze_in", maze_in, 1);
        chk("reset_load_ready", load_ready, 0);
        rst_n = 1'b1;

        // Partial load then asynchronous reset mid-cycle.
        load_cells(100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_load_ready", load_ready, 0);
        chk("midreset_maze_ready", maze_ready, 0);
        chk("midreset_maze_in", maze_in, 1);
        @(negedge clk);
        load_valid = 1'b0;
        maze_oe = 1'b0;
        maze_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        load_cells(4096);
        chk("maze_ready_before_last", maze_ready, 0);
        cyc(0, 0, 0, 0, 0);
        chk("maze_ready_after_last", maze_ready, 1);
        chk("load_ready_after_last", load_ready, 0);
        load_valid = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("load_ready_ignored", load_ready, 0);
        load_valid = 1'b0;

        read_cell(0, 0, 1, "rd_wall_0_0");
        read_cell(1, 1, 0, "rd_free_1_1");
        read_cell(0, 5, 0, "rd_gap_0_5");

        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 1, 1);
        read_cell(1, 1, 0, "rd_visited_1_1");
        chk("count_after_dup", visited_count, 1);

        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("wall_err_set", wall_write_err, 1);
        read_cell(0, 0, 1, "rd_wall_after_we");
        chk("count_after_wall", visited_count, 1);

        cyc(1, 1, 0, 2, 2);
        cyc(0, 0, 0, 0, 0);
        chk("rd_same_cycle_we", maze_in, 0);
        chk("count_after_2_2", visited_count, 2);

        // Random service traffic kept to rows 8..63 so the directed cells stay known.
        for (int k = 0; k < 2000; k++) begin
            cyc($urandom_range(0, 1), ($urandom_range(0, 3) == 0), 0,
                $urandom_range(8, 63), $urandom_range(0, 63));
        end
        cyc(0, 0, 0, 0, 0);
        chk("wall_err_sticky", wall_write_err, 1);

        cnt_before = m_count;
        cyc(0, 1, 1, 0, 5);
        cyc(0, 0, 0, 0, 0);
        chk("count_with_done", visited_count, 32'(cnt_before + 1));
        chk("frozen_set", frozen, 1);
        cyc(0, 1, 0, 3, 3);
        cyc(0, 0, 0, 0, 0);
        chk("count_frozen_we", visited_count, 32'(cnt_before + 1));
        read_cell(3, 3, 0, "rd_frozen_3_3");

`ifdef MAZE_MEM_DUMP_EN
        begin
            int got = 0;
            bit seen_last = 0;
            bit stall = 0;
            logic [1:0] held = '0;
            for (int k = 0; k < 20000 && !seen_last; k++) begin
                @(negedge clk);
                if (stall) chk("dump_hold", dump_data, held);
                dump_ready = $urandom_range(0, 1);
                maze_oe = $urandom_range(0, 1);
                maze_we = $urandom_range(0, 1);
                row = 6'($urandom);
                col = 6'($urandom);
                if (dump_valid && dump_ready) begin
                    chk("dump_data", dump_data, m_cells[got]);
                    chk("dump_last", dump_last, (got == 4095));
                    if (got == 0) chk("dump_0_0", dump_data, 1);
                    if (got == 65) chk("dump_1_1", dump_data, 2);
                    got++;
                    if (dump_last) seen_last = 1;
                end
                stall = dump_valid && !dump_ready;
                held = dump_data;
            end
            @(negedge clk);
            chk("dump_count", got, 4096);
            chk("dump_valid_after", dump_valid, 0);
        end
`else
        for (int k = 0; k < 300; k++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 63), $urandom_range(0, 63));
        end
`endif
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
